// File: rtl/alu_rmw_seq.sv
// -----------------------------------------------------------------------------
// alu_rmw_seq
//   Sequencer for a 6502-style read-modify-write instruction (ASL/LSR/ROL/ROR/
//   INC/DEC on memory).
//
//   The sequence is: read the operand, present it to an external ALU, write
//   the ALU result back, then update the status register.
//   In NMOS mode (DUMMY_WRITE=1) the original operand is written back during
//   the MODIFY cycle.
//
//   Handshake: every non-IDLE state advances only on a cycle where rdy=1.
//   With rdy=0 the state, all latched registers and all outputs hold, and no
//   pulse (done, flag_we) fires. start is looked at only in IDLE.
//   A start seen while busy is dropped, not queued.
//
// Ports
//   clk, reset      : clock; synchronous active-high reset
//   start, op, addr : request (op in shared `OP_* encoding), sampled in IDLE
//   rdy             : bus ready, low = stall
//   mem_addr/rd/wr  : memory bus address and strobes
//   mem_din/dout    : memory read / write data
//   alu_op/alu_arg  : op and operand presented to the external ALU
//   alu_result/sr   : ALU data_out and status {N,V,0,0,0,0,Z,C}
//   flag_we/mask/data : one-cycle status-register update
//   busy, done, err : in progress, completion pulse, illegal-op pulse
//   state_dbg       : current FSM state (IDLE=0, READ=1, MODIFY=2, WRITE=3)
// -----------------------------------------------------------------------------
`ifndef OP_ADD
`define OP_ADD 4'h0
`define OP_SUB 4'h1
`define OP_AND 4'h2
`define OP_OR  4'h3
`define OP_EOR 4'h4
`define OP_ASL 4'h5
`define OP_LSR 4'h6
`define OP_ROL 4'h7
`define OP_ROR 4'h8
`define OP_INC 4'h9
`define OP_DEC 4'hA
`define OP_CMP 4'hB
`define OP_BIT 4'hC
`endif

module alu_rmw_seq #(
    parameter int ADDR_W      = 16,
    parameter bit DUMMY_WRITE = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [3:0]        op,
    input  logic [ADDR_W-1:0] addr,
    input  logic              rdy,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    output logic              mem_wr,
    input  logic [7:0]        mem_din,
    output logic [7:0]        mem_dout,
    output logic [3:0]        alu_op,
    output logic [7:0]        alu_arg,
    input  logic [7:0]        alu_result,
    input  logic [7:0]        alu_sr,
    output logic              flag_we,
    output logic [7:0]        flag_mask,
    output logic [7:0]        flag_data,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [1:0]        state_dbg
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        READ   = 2'd1,
        MODIFY = 2'd2,
        WRITE  = 2'd3
    } state_t;

    state_t            state;
    logic [3:0]        op_q;
    logic [ADDR_W-1:0] addr_q;
    logic [7:0]        operand_q;
    logic [7:0]        result_q;
    logic [7:0]        flags_q;
    logic              op_legal;
    logic              op_is_shift;

    always_comb begin
        op_legal = 1'b0;
        case (op)
            `OP_ASL, `OP_LSR, `OP_ROL, `OP_ROR, `OP_INC, `OP_DEC: op_legal = 1'b1;
            default: op_legal = 1'b0;
        endcase
    end

    // Shifts and rotates own the carry; INC/DEC leave C untouched.
    always_comb begin
        op_is_shift = 1'b0;
        case (op_q)
            `OP_ASL, `OP_LSR, `OP_ROL, `OP_ROR: op_is_shift = 1'b1;
            default: op_is_shift = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            op_q      <= 4'h0;
            addr_q    <= '0;
            operand_q <= 8'h00;
            result_q  <= 8'h00;
            flags_q   <= 8'h00;
        end else begin
            case (state)
                IDLE: begin
                    if (start && op_legal) begin
                        op_q   <= op;
                        addr_q <= addr;
                        state  <= READ;
                    end
                end
                READ: begin
                    if (rdy) begin
                        operand_q <= mem_din;
                        state     <= MODIFY;
                    end
                end
                MODIFY: begin
                    if (rdy) begin
                        result_q <= alu_result;
                        flags_q  <= alu_sr;
                        state    <= WRITE;
                    end
                end
                WRITE: begin
                    if (rdy) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Outputs are a pure decode of the registered state and latches, so they
    // change on the same edge as the state. done/flag_we/err are qualified by
    // the current-cycle rdy/start, which is what makes them single-cycle
    // pulses. Everything is forced to 0 while reset is high, including the
    // cycle before the state register has returned to IDLE.
    always_comb begin
        mem_addr  = '0;
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        mem_dout  = 8'h00;
        alu_op    = 4'h0;
        alu_arg   = 8'h00;
        flag_we   = 1'b0;
        flag_mask = 8'h00;
        flag_data = 8'h00;
        busy      = 1'b0;
        done      = 1'b0;
        err       = 1'b0;
        state_dbg = 2'd0;
        if (!reset) begin
            state_dbg = state;
            case (state)
                IDLE: begin
                    err = start && !op_legal;
                end
                READ: begin
                    busy     = 1'b1;
                    mem_addr = addr_q;
                    mem_rd   = 1'b1;
                end
                MODIFY: begin
                    busy     = 1'b1;
                    mem_addr = addr_q;
                    alu_op   = op_q;
                    alu_arg  = operand_q;
                    if (DUMMY_WRITE) begin
                        mem_wr   = 1'b1;
                        mem_dout = operand_q;
                    end
                end
                WRITE: begin
                    busy      = 1'b1;
                    mem_addr  = addr_q;
                    mem_wr    = 1'b1;
                    mem_dout  = result_q;
                    flag_mask = op_is_shift ? 8'h83 : 8'h82;
                    flag_data = flags_q;
                    flag_we   = rdy;
                    done      = rdy;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_rmw_seq.sv
`timescale 1ns/1ps
`ifndef OP_ADD
`define OP_ADD 4'h0
`define OP_SUB 4'h1
`define OP_AND 4'h2
`define OP_OR  4'h3
`define OP_EOR 4'h4
`define OP_ASL 4'h5
`define OP_LSR 4'h6
`define OP_ROL 4'h7
`define OP_ROR 4'h8
`define OP_INC 4'h9
`define OP_DEC 4'hA
`define OP_CMP 4'hB
`define OP_BIT 4'hC
`endif

module tb_alu_rmw_seq;

  localparam int VW = 58;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  op = 4'h0;
  logic [15:0] addr = 16'h0;
  logic        rdy = 1'b0;
  logic [7:0]  mem_din = 8'h0;
  logic        alu_cin = 1'b0;

  // dut1: DUMMY_WRITE=1, dut0: DUMMY_WRITE=0; shared inputs
  logic [15:0] mem_addr1, mem_addr0;
  logic        mem_rd1, mem_rd0, mem_wr1, mem_wr0;
  logic [7:0]  mem_dout1, mem_dout0;
  logic [3:0]  alu_op1, alu_op0;
  logic [7:0]  alu_arg1, alu_arg0, alu_result1, alu_result0, alu_sr1, alu_sr0;
  logic        flag_we1, flag_we0;
  logic [7:0]  flag_mask1, flag_mask0, flag_data1, flag_data0;
  logic        busy1, busy0, done1, done0, err1, err0;
  logic [1:0]  state_dbg1, state_dbg0;

  alu_rmw_seq #(.ADDR_W(16), .DUMMY_WRITE(1'b1)) dut1 (
    .clk(clk), .reset(reset), .start(start), .op(op), .addr(addr), .rdy(rdy),
    .mem_addr(mem_addr1), .mem_rd(mem_rd1), .mem_wr(mem_wr1), .mem_din(mem_din),
    .mem_dout(mem_dout1), .alu_op(alu_op1), .alu_arg(alu_arg1),
    .alu_result(alu_result1), .alu_sr(alu_sr1), .flag_we(flag_we1),
    .flag_mask(flag_mask1), .flag_data(flag_data1), .busy(busy1), .done(done1),
    .err(err1), .state_dbg(state_dbg1)
  );

  alu_rmw_seq #(.ADDR_W(16), .DUMMY_WRITE(1'b0)) dut0 (
    .clk(clk), .reset(reset), .start(start), .op(op), .addr(addr), .rdy(rdy),
    .mem_addr(mem_addr0), .mem_rd(mem_rd0), .mem_wr(mem_wr0), .mem_din(mem_din),
    .mem_dout(mem_dout0), .alu_op(alu_op0), .alu_arg(alu_arg0),
    .alu_result(alu_result0), .alu_sr(alu_sr0), .flag_we(flag_we0),
    .flag_mask(flag_mask0), .flag_data(flag_data0), .busy(busy0), .done(done0),
    .err(err0), .state_dbg(state_dbg0)
  );

  // ---------------- reference ALU (plain arithmetic) ----------------
  // returns {sr, result}; sr = {N,V,0,0,0,0,Z,C}
  function automatic logic [15:0] ref_alu(input logic [3:0] o, input logic [7:0] a, input logic ci);
    int v;
    int c;
    logic [7:0] r;
    c = int'(ci);
    case (o)
      `OP_ASL: begin v = int'(a) * 2;             c = v / 256;        end
      `OP_LSR: begin v = int'(a) / 2;             c = int'(a) % 2;    end
      `OP_ROL: begin v = int'(a) * 2 + int'(ci);  c = v / 256;        end
      `OP_ROR: begin v = int'(a) / 2 + int'(ci) * 128; c = int'(a) % 2; end
      `OP_INC: v = int'(a) + 1;
      `OP_DEC: v = int'(a) + 255;
      default: v = int'(a);
    endcase
    r = 8'(v % 256);
    return {r[7], 1'b0, 4'b0000, (r == 8'h00), c[0], r};
  endfunction

  assign {alu_sr1, alu_result1} = ref_alu(alu_op1, alu_arg1, alu_cin);
  assign {alu_sr0, alu_result0} = ref_alu(alu_op0, alu_arg0, alu_cin);

  function automatic logic [VW-1:0] pack(input logic b, input logic rd, input logic wr,
                                         input logic [15:0] ad, input logic [7:0] dout,
                                         input logic [3:0] ao, input logic [7:0] aa,
                                         input logic fwe, input logic [7:0] fm,
                                         input logic [7:0] fd, input logic dn, input logic er);
    return {b, rd, wr, ad, dout, ao, aa, fwe, fm, fd, dn, er};
  endfunction

  wire [VW-1:0] obs1 = {busy1, mem_rd1, mem_wr1, mem_addr1, mem_dout1, alu_op1, alu_arg1,
                        flag_we1, flag_mask1, flag_data1, done1, err1};
  wire [VW-1:0] obs0 = {busy0, mem_rd0, mem_wr0, mem_addr0, mem_dout0, alu_op0, alu_arg0,
                        flag_we0, flag_mask0, flag_data0, done0, err0};

  // ---------------- scoreboard ----------------
  int checks = 0;
  int passes = 0;
  logic [23:0] exp_q[$];
  logic [23:0] sb_v;

  // every completion of the NMOS instance must match the oldest expected write
  always @(negedge clk) begin
    if (done1 === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL sb_unexpected_done got addr=%h data=%h expected no completion",
                 mem_addr1, mem_dout1);
      end else begin
        sb_v = exp_q.pop_front();
        if ({mem_addr1, mem_dout1} !== sb_v)
          $display("FAIL sb_write got addr=%h data=%h expected addr=%h data=%h",
                   mem_addr1, mem_dout1, sb_v[23:8], sb_v[7:0]);
        else passes++;
      end
    end
  end

  function automatic bit is_legal(input logic [3:0] o);
    return (o == `OP_ASL) || (o == `OP_LSR) || (o == `OP_ROL) ||
           (o == `OP_ROR) || (o == `OP_INC) || (o == `OP_DEC);
  endfunction

  // ---------------- driver: one full transaction, cycle-checked ----------------
  task automatic run_op(input string name, input logic [3:0] o, input logic [15:0] a,
                        input logic [7:0] d, input logic ci, input int sr, input int sm,
                        input int sw, input bit noise,
                        output logic [7:0] wdata, output logic [7:0] fdata,
                        output logic [7:0] fmask, output int n_done, output int n_fwe,
                        output int n_wr3, output int done_cyc);
    logic [15:0] rv;
    logic [7:0] exp_r, exp_f, exp_m;
    logic [VW-1:0] e1, e0, c1, c0;
    bit legal;
    int ph, stall, cyc;
    rv = ref_alu(o, d, ci);
    exp_r = rv[7:0];
    exp_f = rv[15:8];
    exp_m = ((o == `OP_INC) || (o == `OP_DEC)) ? 8'h82 : 8'h83;
    legal = is_legal(o);
    wdata = 8'h00; fdata = 8'h00; fmask = 8'h00;
    n_done = 0; n_fwe = 0; n_wr3 = 0; done_cyc = -1;
    if (legal) exp_q.push_back({a, exp_r});
    ph = 0; stall = 0; cyc = 0;
    while (ph < 4) begin
      @(posedge clk); #1;
      if (ph == 0) begin
        start = 1'b1; op = o; addr = a;
        rdy = 1'($urandom_range(0, 1));
        mem_din = 8'($urandom);
        alu_cin = ci;
      end else begin
        start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        if (noise) begin op = 4'($urandom); addr = 16'($urandom); end
        rdy = (ph == 1) ? (stall == sr) : (ph == 2) ? (stall == sm) : (stall == sw);
        mem_din = (ph == 1 && rdy) ? d : 8'($urandom);
        alu_cin = (ph == 2 && !rdy) ? 1'($urandom) : ci;
      end
      @(negedge clk);
      e1 = '0; c1 = '0;
      case (ph)
        0: begin
          e1 = pack(1'b0, 1'b0, 1'b0, 16'h0, 8'h0, 4'h0, 8'h0, 1'b0, 8'h0, 8'h0, 1'b0, !legal);
          c1 = pack(1'b1, 1'b1, 1'b1, 16'h0, 8'h0, 4'h0, 8'h0, 1'b1, 8'h0, 8'h0, 1'b1, 1'b1);
        end
        1: begin
          e1 = pack(1'b1, 1'b1, 1'b0, a, 8'h0, 4'h0, 8'h0, 1'b0, 8'h0, 8'h0, 1'b0, 1'b0);
          c1 = pack(1'b1, 1'b1, 1'b1, 16'hFFFF, 8'h0, 4'h0, 8'h0, 1'b1, 8'h0, 8'h0, 1'b1, 1'b1);
        end
        2: begin
          e1 = pack(1'b1, 1'b0, 1'b1, a, d, o, d, 1'b0, 8'h0, 8'h0, 1'b0, 1'b0);
          c1 = pack(1'b1, 1'b1, 1'b1, 16'hFFFF, 8'hFF, 4'hF, 8'hFF, 1'b1, 8'h0, 8'h0, 1'b1, 1'b1);
        end
        default: begin
          e1 = pack(1'b1, 1'b0, 1'b1, a, exp_r, 4'h0, 8'h0, rdy, exp_m, exp_f, rdy, 1'b0);
          c1 = pack(1'b1, 1'b1, 1'b1, 16'hFFFF, 8'hFF, 4'h0, 8'h0, 1'b1,
                    rdy ? 8'hFF : 8'h00, rdy ? 8'hFF : 8'h00, 1'b1, 1'b1);
        end
      endcase
      // without dummy write: no strobe and no data to care about in MODIFY
      e0 = e1; c0 = c1;
      if (ph == 2) begin
        e0 = pack(1'b1, 1'b0, 1'b0, a, 8'h0, o, d, 1'b0, 8'h0, 8'h0, 1'b0, 1'b0);
        c0 = pack(1'b1, 1'b1, 1'b1, 16'hFFFF, 8'h0, 4'hF, 8'hFF, 1'b1, 8'h0, 8'h0, 1'b1, 1'b1);
      end
      checks++;
      if ((obs1 & c1) !== (e1 & c1))
        $display("FAIL %s dut1 ph%0d cyc%0d got %h expected %h (care %h)", name, ph, cyc,
                 obs1 & c1, e1 & c1, c1);
      else passes++;
      checks++;
      if ((obs0 & c0) !== (e0 & c0))
        $display("FAIL %s dut0 ph%0d cyc%0d got %h expected %h (care %h)", name, ph, cyc,
                 obs0 & c0, e0 & c0, c0);
      else passes++;
      if (done1 === 1'b1) begin
        n_done++; done_cyc = cyc;
        wdata = mem_dout1; fdata = flag_data1; fmask = flag_mask1;
      end
      if (flag_we1 === 1'b1) n_fwe++;
      if (ph == 3 && mem_wr1 === 1'b1 && mem_dout1 === exp_r) n_wr3++;
      if (ph == 0) ph = legal ? 1 : 4;
      else if (rdy) begin ph++; stall = 0; end
      else stall++;
      cyc++;
    end
  endtask

  task automatic idle_cycles(input string name, input int n);
    logic [VW-1:0] c;
    c = pack(1'b1, 1'b1, 1'b1, 16'h0, 8'h0, 4'h0, 8'h0, 1'b1, 8'h0, 8'h0, 1'b1, 1'b1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      start = 1'b0; rdy = 1'($urandom_range(0, 1));
      op = 4'($urandom); addr = 16'($urandom); mem_din = 8'($urandom);
      @(negedge clk);
      checks++;
      if ((obs1 & c) !== '0 || (obs0 & c) !== '0)
        $display("FAIL %s idle%0d got dut1=%h dut0=%h expected 0", name, i, obs1 & c, obs0 & c);
      else passes++;
    end
  endtask

  // ---------------- scenarios ----------------
  logic [7:0] r_w, r_f, r_m;
  int r_nd, r_nf, r_nw, r_dc;

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      reset = 1'b1; start = 1'b1; op = `OP_ASL; addr = 16'($urandom);
      rdy = 1'($urandom_range(0, 1));
      @(negedge clk);
      checks++;
      if (obs1 !== '0 || obs0 !== '0 || state_dbg1 !== 2'd0)
        $display("FAIL reset_outputs got dut1=%h dut0=%h expected 0", obs1, obs0);
      else passes++;
    end
    @(posedge clk); #1;
    reset = 1'b0; start = 1'b0;
    idle_cycles("after_reset", 2);
  endtask

  task automatic test_asl();
    run_op("asl", `OP_ASL, 16'h0010, 8'h81, 1'b0, 0, 0, 0, 1'b0, r_w, r_f, r_m, r_nd, r_nf, r_nw, r_dc);
    checks++;
    if (r_w !== 8'h02 || r_f !== 8'h01 || r_m !== 8'h83 || r_dc !== 3 || r_nd !== 1)
      $display("FAIL asl got w=%h f=%h m=%h done_cyc=%0d n=%0d expected w=02 f=01 m=83 done_cyc=3 n=1",
               r_w, r_f, r_m, r_dc, r_nd);
    else passes++;
  endtask

  task automatic test_inc_wrap();
    run_op("inc", `OP_INC, 16'h01FF, 8'hFF, 1'b0, 0, 0, 0, 1'b0, r_w, r_f, r_m, r_nd, r_nf, r_nw, r_dc);
    checks++;
    if (r_w !== 8'h00 || r_f !== 8'h02 || r_m !== 8'h82)
      $display("FAIL inc got w=%h f=%h m=%h expected w=00 f=02 m=82", r_w, r_f, r_m);
    else passes++;
  endtask

  task automatic test_ror();
    run_op("ror", `OP_ROR, 16'h1234, 8'h01, 1'b1, 0, 0, 0, 1'b0, r_w, r_f, r_m, r_nd, r_nf, r_nw, r_dc);
    checks++;
    if (r_w !== 8'h80 || r_f !== 8'h81 || r_m !== 8'h83)
      $display("FAIL ror got w=%h f=%h m=%h expected w=80 f=81 m=83", r_w, r_f, r_m);
    else passes++;
  endtask

  task automatic test_addr_wrap();
    run_op("dec_ffff", `OP_DEC, 16'hFFFF, 8'h00, 1'b1, 1, 1, 0, 1'b1, r_w, r_f, r_m, r_nd, r_nf, r_nw, r_dc);
    checks++;
    if (r_w !== 8'hFF || r_f !== 8'h81 || r_m !== 8'h82)
      $display("FAIL dec_ffff got w=%h f=%h m=%h expected w=ff f=81 m=82", r_w, r_f, r_m);
    else passes++;
  endtask

  task automatic test_stall_write();
    run_op("stall_wr", `OP_LSR, 16'h0200, 8'($urandom), 1'b0, 0, 0, 2, 1'b1,
           r_w, r_f, r_m, r_nd, r_nf, r_nw, r_dc);
    checks++;
    if (r_nw !== 3 || r_nd !== 1 || r_nf !== 1 || r_dc !== 5)
      $display("FAIL stall_wr got wr_cycles=%0d done=%0d flag_we=%0d done_cyc=%0d expected 3 1 1 5",
               r_nw, r_nd, r_nf, r_dc);
    else passes++;
  endtask

  task automatic test_illegal();
    run_op("illegal_add", `OP_ADD, 16'h0300, 8'h55, 1'b0, 0, 0, 0, 1'b0,
           r_w, r_f, r_m, r_nd, r_nf, r_nw, r_dc);
    checks++;
    if (r_nd !== 0 || r_nf !== 0)
      $display("FAIL illegal_add got done=%0d flag_we=%0d expected 0 0", r_nd, r_nf);
    else passes++;
    idle_cycles("after_illegal", 2);
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #1;
    start = 1'b1; op = `OP_INC; addr = 16'h0400; rdy = 1'b1;
    @(posedge clk); #1;                // READ
    start = 1'b0; rdy = 1'b1; mem_din = 8'h10;
    @(posedge clk); #1;                // MODIFY, reset asserted here
    reset = 1'b1; rdy = 1'b1; start = 1'b1;
    @(negedge clk);
    checks++;
    if (obs1 !== '0 || obs0 !== '0)
      $display("FAIL reset_mid_now got dut1=%h dut0=%h expected 0", obs1, obs0);
    else passes++;
    @(posedge clk); #1;
    reset = 1'b0; start = 1'b0; rdy = 1'b1;
    @(negedge clk);
    checks++;
    if (obs1 !== '0 || obs0 !== '0 || state_dbg1 !== 2'd0)
      $display("FAIL reset_mid_next got dut1=%h dut0=%h expected 0", obs1, obs0);
    else passes++;
    idle_cycles("after_reset_mid", 4);
  endtask

  task automatic test_back_to_back();
    logic [3:0] o;
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 7) == 0) o = 4'($urandom_range(11, 15));
      else o = 4'($urandom_range(5, 10));
      run_op("b2b", o, 16'($urandom), 8'($urandom), 1'($urandom),
             $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2), 1'b1,
             r_w, r_f, r_m, r_nd, r_nf, r_nw, r_dc);
    end
    idle_cycles("after_b2b", 2);
  endtask

  initial begin
    test_reset();
    test_asl();
    test_inc_wrap();
    test_ror();
    test_addr_wrap();
    test_stall_write();
    test_illegal();
    test_reset_mid();
    test_back_to_back();
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0)
      $display("FAIL sb_drain got %0d outstanding expected 0", exp_q.size());
    else passes++;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/alu_rmw_seq.md
ALU_RMW_SEQ -- requirements
Module: alu_rmw_seq

Interface
REQ-001 Parameter ADDR_W, default 16: width of the memory address bus.
REQ-002 Parameter DUMMY_WRITE, default 1: 1 = write the original operand back during MODIFY (NMOS 6502 behaviour); 0 = no bus write in MODIFY.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset  input  1  reset, synchronous to clk and active-high.
REQ-005 start  input  1  request one read-modify-write; sampled in IDLE only.
REQ-006 op  input  4  ALU op code, using the shared `OP_* encoding; legal values are ASL, LSR, ROL, ROR, INC and DEC.
REQ-007 addr  input  ADDR_W  target address; sampled with start.
REQ-008 rdy  input  1  bus ready; low = stall.
REQ-009 mem_addr  output  ADDR_W  bus address.
REQ-010 mem_rd  output  1  bus read strobe.
REQ-011 mem_wr  output  1  bus write strobe.
REQ-012 mem_din  input  8  read data.
REQ-013 mem_dout  output  8  write data.
REQ-014 alu_op  output  4  op driven to the ALU.
REQ-015 alu_arg  output  8  operand register driven to the ALU argument.
REQ-016 alu_result  input  8  ALU data_out.
REQ-017 alu_sr  input  8  ALU sr_data {N,V,0,0,0,0,Z,C}.
REQ-018 flag_we  output  1  one-cycle status-register update strobe.
REQ-019 flag_mask  output  8  status bits to update.
REQ-020 flag_data  output  8  status values.
REQ-021 busy  output  1  operation in progress.
REQ-022 done  output  1  one-cycle completion pulse.
REQ-023 err  output  1  one-cycle illegal-op pulse.

Function
REQ-024 FSM states SHALL be IDLE, READ, MODIFY and WRITE.
REQ-025 IDLE, start=1, legal op: latch op and addr; next state READ.
REQ-026 IDLE, start=1, illegal op: assert err for one cycle; stay in IDLE; perform no bus access.
REQ-027 READ: mem_addr=addr and mem_rd=1; when rdy=1, latch mem_din into the operand register and go to MODIFY.
REQ-028 MODIFY: alu_op=latched op and alu_arg=operand, both held stable.
REQ-029 MODIFY, DUMMY_WRITE=1: mem_wr=1 with mem_dout=operand.
REQ-030 MODIFY: when rdy=1, latch alu_result into the result register and alu_sr into the flag register; go to WRITE.
REQ-031 WRITE: mem_wr=1 and mem_dout=result; when rdy=1, assert flag_we and done for that cycle and go to IDLE.
REQ-032 flag_mask SHALL be 8'h83 (N,Z,C) for ASL, LSR, ROL and ROR, and 8'h82 (N,Z) for INC and DEC.
REQ-033 flag_data SHALL be the register latched in MODIFY; all arithmetic is 8-bit and wraps ($FF+1=$00, $00-1=$FF).
REQ-034 rdy=0 in any non-IDLE state SHALL hold the state and every output stable; no latches update and no pulses fire.
REQ-035 Unstalled latency: start at cycle 0; READ in cycle 1; MODIFY in cycle 2; WRITE with done in cycle 3; a new start is accepted in cycle 4.
REQ-036 busy=1 exactly while the FSM is not in IDLE; start while busy SHALL be ignored, not queued.
REQ-037 mem_rd and mem_wr SHALL never both be 1; both SHALL be 0 in IDLE.
REQ-038 mem_addr SHALL equal the latched addr in READ, MODIFY and WRITE, including wrap at address all-ones.

Reset
REQ-039 While reset=1, the FSM SHALL go to IDLE at the next edge from any state and all outputs SHALL be 0 (alu_op=0, mem_addr=0).
REQ-040 Reset asserted mid-operation SHALL abort it: no done, flag_we or pending WRITE is issued afterwards.
REQ-041 reset SHALL take priority over start and rdy.

Verification
REQ-042 ASL at $0010 with mem[$0010]=$81, rdy=1 -> read $81; dummy write $81; write $02; flag_data N=0 Z=0 C=1; flag_mask $83; done in cycle 3.
REQ-043 INC at $01FF with data $FF -> write $00; Z=1, N=0; flag_mask $82.
REQ-044 ROR with carry-in 1, data $01, DUMMY_WRITE=0 -> no write in MODIFY; write $80; N=1, C=1.
REQ-045 rdy=0 for 2 cycles in WRITE -> mem_wr and data held for 3 cycles; a single done; flag_we once.
REQ-046 reset=1 during MODIFY -> next cycle IDLE, all outputs 0; no further writes, done or flag_we.
REQ-047 start with op=`OP_ADD in IDLE -> err pulse only; busy stays 0; no mem_rd or mem_wr.
